// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one multiplier between N_REQ requesters.
// It latches the winner's operands and drives the start/done/clear handshake,
// then returns the product, or a timeout error, to the requester that won.
module mul_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic                     rsp_err,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     busy,
    output logic [WIDTH-1:0]         mul_multiplier,
    output logic [WIDTH-1:0]         mul_multiplicand,
    output logic                     mul_op_start,
    output logic                     mul_op_clear,
    input  logic [2*WIDTH-1:0]       mul_result,
    input  logic                     mul_op_done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CLEAR
    } state_t;

    state_t                 r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_sel;
    logic [WD_W-1:0]        r_wd;
    logic [N_REQ-1:0]       r_grant;
    logic [N_REQ-1:0]       r_rsp_valid;
    logic                   r_rsp_err;
    logic [2*WIDTH-1:0]     r_rsp_result;
    logic                   r_busy;
    logic [WIDTH-1:0]       r_mult;
    logic [WIDTH-1:0]       r_mcand;
    logic                   r_start;
    logic                   r_clear;

    logic [2*N_REQ-1:0]     w_dbl;
    logic [2*N_REQ-1:0]     w_shift;
    logic [N_REQ-1:0]       w_rot;
    logic                   w_any;
    logic [PTR_W:0]         w_off;
    logic [PTR_W:0]         w_sum;
    logic [PTR_W-1:0]       w_sel;
    logic [PTR_W-1:0]       w_ptr_next;
    logic [WIDTH-1:0]       w_a;
    logic [WIDTH-1:0]       w_b;

    // Rotate the request vector so bit 0 is the slot the pointer names.
    assign w_dbl   = {req, req};
    assign w_shift = w_dbl >> r_ptr;
    assign w_rot   = w_shift[N_REQ-1:0];
    assign w_any   = |req;

    // Round-robin pick: first set request at or above the pointer, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = (PTR_W+1)'(k);
        end
        w_sum = {1'b0, r_ptr} + w_off;
        if (w_sum >= (PTR_W+1)'(N_REQ)) w_sel = PTR_W'(w_sum - (PTR_W+1)'(N_REQ));
        else                            w_sel = PTR_W'(w_sum);
    end

    // Operand mux for the selected slot.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == PTR_W'(i)) begin
                w_a = req_a[i*WIDTH +: WIDTH];
                w_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // The owner's successor becomes the highest-priority slot next time round.
    assign w_ptr_next = (r_sel == PTR_W'(N_REQ - 1)) ? '0 : r_sel + PTR_W'(1);

    // Handshake sequencer: every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_sel        <= '0;
            r_wd         <= '0;
            r_grant      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_result <= '0;
            r_busy       <= 1'b0;
            r_mult       <= '0;
            r_mcand      <= '0;
            r_start      <= 1'b0;
            r_clear      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_sel;
                        r_grant <= N_REQ'(1) << w_sel;
                        r_busy  <= 1'b1;
                        r_mult  <= w_a;
                        r_mcand <= w_b;
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_start <= 1'b0;
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wd <= r_wd + WD_W'(1);
                    if (mul_op_done) begin
                        r_rsp_result <= mul_result;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= r_grant;
                        r_clear      <= 1'b1;
                        r_state      <= S_CLEAR;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_rsp_result <= '0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= r_grant;
                        r_clear      <= 1'b1;
                        r_state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_clear     <= 1'b0;
                    r_rsp_valid <= '0;
                    r_rsp_err   <= 1'b0;
                    r_grant     <= '0;
                    r_busy      <= 1'b0;
                    r_ptr       <= w_ptr_next;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant            = r_grant;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_err          = r_rsp_err;
    assign rsp_result       = r_rsp_result;
    assign busy             = r_busy;
    assign mul_multiplier   = r_mult;
    assign mul_multiplicand = r_mcand;
    assign mul_op_start     = r_start;
    assign mul_op_clear     = r_clear;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level model of arbitration and response timing checked every cycle.
module tb_mul_arbiter;

    localparam int N  = 2;
    localparam int W  = 64;
    localparam int TO = 255;

    logic                 clk;
    logic                 reset_n;
    logic [N-1:0]         req;
    logic [N*W-1:0]       req_a;
    logic [N*W-1:0]       req_b;
    logic [N-1:0]         grant;
    logic [N-1:0]         rsp_valid;
    logic                 rsp_err;
    logic [2*W-1:0]       rsp_result;
    logic                 busy;
    logic [W-1:0]         mul_multiplier;
    logic [W-1:0]         mul_multiplicand;
    logic                 mul_op_start;
    logic                 mul_op_clear;
    logic [2*W-1:0]       mul_result;
    logic                 mul_op_done;

    mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .req_a            (req_a),
        .req_b            (req_b),
        .grant            (grant),
        .rsp_valid        (rsp_valid),
        .rsp_err          (rsp_err),
        .rsp_result       (rsp_result),
        .busy             (busy),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_op_start     (mul_op_start),
        .mul_op_clear     (mul_op_clear),
        .mul_result       (mul_result),
        .mul_op_done      (mul_op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- multiplier stub ----------------
    logic stub_hang;
    logic stub_stale;
    int   stub_lat;
    logic stub_pend;
    int   stub_cnt;
    logic signed [2*W-1:0] stub_x, stub_y, stub_prod;
    assign stub_x    = $signed(mul_multiplier);
    assign stub_y    = $signed(mul_multiplicand);
    assign stub_prod = stub_x * stub_y;

    // Behavioural multiplier: done after stub_lat cycles, held until clear.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_op_done <= 1'b0;
            mul_result  <= '0;
            stub_pend   <= 1'b0;
            stub_cnt    <= 0;
        end else if (mul_op_clear) begin
            mul_op_done <= 1'b0;
        end else if (mul_op_start) begin
            if (stub_hang) begin
                mul_op_done <= 1'b0;
                stub_pend   <= 1'b0;
            end else if (stub_lat == 0) begin
                mul_op_done <= 1'b1;
                mul_result  <= stub_prod;
                stub_pend   <= 1'b0;
            end else begin
                mul_op_done <= 1'b0;
                stub_pend   <= 1'b1;
                stub_cnt    <= stub_lat - 1;
            end
        end else if (stub_pend) begin
            if (stub_cnt == 0) begin
                mul_op_done <= 1'b1;
                mul_result  <= stub_prod;
                stub_pend   <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end else if (stub_stale) begin
            mul_op_done <= 1'b1;
            mul_result  <= {2*W{1'b1}};
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // An operation is a timeline measured in cycles since grant: cycle 0 pulses
    // start, done counts from cycle 1, and the response appears the cycle after
    // done or after TO waiting cycles; one clear cycle later the slot is free.
    logic          m_busy;
    logic          m_resp;
    int            m_owner;
    int            m_ptr;
    int            m_age;
    logic [W-1:0]  exp_a, exp_b;
    logic [2*W-1:0] exp_result;
    logic [N-1:0]  exp_grant, exp_valid;
    logic          exp_err, exp_busy, exp_start, exp_clear;

    function automatic int pick(input int ptr, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_resp = 1'b0; m_owner = 0; m_ptr = 0; m_age = 0;
        exp_a = '0; exp_b = '0; exp_result = '0;
        exp_grant = '0; exp_valid = '0; exp_err = 1'b0;
        exp_busy = 1'b0; exp_start = 1'b0; exp_clear = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] sr, input logic [N*W-1:0] sa,
                              input logic [N*W-1:0] sb, input logic sd);
        logic signed [2*W-1:0] xa, xb;
        exp_start = 1'b0; exp_clear = 1'b0; exp_valid = '0; exp_err = 1'b0;
        if (!m_busy) begin
            if (sr != '0) begin
                m_owner = pick(m_ptr, sr);
                m_busy = 1'b1; m_resp = 1'b0; m_age = 0;
                exp_a = sa[m_owner*W +: W];
                exp_b = sb[m_owner*W +: W];
                exp_start = 1'b1;
            end
        end else if (m_resp) begin
            m_busy = 1'b0;
            m_ptr = (m_owner + 1) % N;
        end else begin
            if (m_age >= 1 && sd) begin
                xa = $signed(exp_a);
                xb = $signed(exp_b);
                exp_result = xa * xb;
                exp_valid = N'(1) << m_owner;
                exp_clear = 1'b1;
                m_resp = 1'b1;
            end else if (m_age == TO) begin
                exp_result = '0;
                exp_err = 1'b1;
                exp_valid = N'(1) << m_owner;
                exp_clear = 1'b1;
                m_resp = 1'b1;
            end
            m_age++;
        end
        exp_busy  = m_busy;
        exp_grant = m_busy ? (N'(1) << m_owner) : '0;
    endtask

    // ---------------- cycle bookkeeping ----------------
    int   cyc = 0;
    int   grant_cyc = 0;
    int   n_start = 0;
    int   n_clear = 0;
    int   n_valid [N];
    int   grant_log[$];
    logic [N-1:0] prev_grant;

    // Advance one clock: model the edge from the inputs applied before it, then compare.
    task automatic tick();
        logic [N-1:0]   sr;
        logic [N*W-1:0] sa, sb;
        logic           sd;
        sr = req; sa = req_a; sb = req_b; sd = mul_op_done;
        @(posedge clk);
        #1;
        cyc++;
        model_step(sr, sa, sb, sd);
        check("grant",            grant,            exp_grant);
        check("busy",             busy,             exp_busy);
        check("mul_op_start",     mul_op_start,     exp_start);
        check("mul_op_clear",     mul_op_clear,     exp_clear);
        check("rsp_valid",        rsp_valid,        exp_valid);
        check("rsp_err",          rsp_err,          exp_err);
        check("rsp_result",       rsp_result,       exp_result);
        check("mul_multiplier",   mul_multiplier,   exp_a);
        check("mul_multiplicand", mul_multiplicand, exp_b);
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
            grant_cyc = cyc;
        end
        prev_grant = grant;
        if (mul_op_start) n_start++;
        if (mul_op_clear) n_clear++;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) n_valid[i]++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"},   grant,            '0);
        check({tag, "_valid"},   rsp_valid,        '0);
        check({tag, "_err"},     rsp_err,          '0);
        check({tag, "_result"},  rsp_result,       '0);
        check({tag, "_busy"},    busy,             '0);
        check({tag, "_start"},   mul_op_start,     '0);
        check({tag, "_clear"},   mul_op_clear,     '0);
        check({tag, "_mult"},    mul_multiplier,   '0);
        check({tag, "_mcand"},   mul_multiplicand, '0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        model_reset();
        prev_grant = '0;
        reset_n = 1'b1;
    endtask

    task automatic set_ops(input int slot, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[slot*W +: W] = a;
        req_b[slot*W +: W] = b;
    endtask

    // Run until rsp_valid[slot] pulses (bounded); the requester then drops req.
    task automatic wait_rsp(input int slot, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (rsp_valid[slot]) seen = 1'b1;
        end
        check($sformatf("rsp_seen_slot%0d", slot), seen, 1'b1);
        req[slot] = 1'b0;
    endtask

    task automatic wait_grant(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (grant != '0) seen = 1'b1;
        end
        check("grant_seen", seen, 1'b1);
    endtask

    localparam logic [2*W-1:0] NEG49 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFCF;

    initial begin
        int v1_before;
        reset_n = 1'b0; req = '0; req_a = '0; req_b = '0;
        stub_hang = 1'b0; stub_stale = 1'b0; stub_lat = 2;
        for (int i = 0; i < N; i++) n_valid[i] = 0;
        prev_grant = '0;
        model_reset();

        // Single request, 7 * -7.
        do_reset();
        n_start = 0; n_clear = 0; grant_log.delete();
        set_ops(0, 64'd7, -64'sd7);
        req = 2'b01;
        wait_rsp(0, 40);
        check("t1_result", rsp_result, NEG49);
        check("t1_err", rsp_err, 1'b0);
        tick();
        tick();
        check("t1_busy_after", busy, 1'b0);
        check("t1_starts", n_start, 1);
        check("t1_clears", n_clear, 1);
        check("t1_grant_slot", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        // Both requesters right after reset.
        do_reset();
        for (int i = 0; i < N; i++) n_valid[i] = 0;
        set_ops(0, 64'd945, 64'd1234);
        set_ops(1, -64'sd159, -64'sd753);
        req = 2'b11;
        wait_rsp(0, 40);
        check("t2_slot0_result", rsp_result, 128'd1166130);
        wait_rsp(1, 40);
        check("t2_slot1_result", rsp_result, 128'd119727);
        repeat (3) tick();
        check("t2_valid_slot0", n_valid[0], 1);
        check("t2_valid_slot1", n_valid[1], 1);

        // Continuous requests on both slots: grants must alternate.
        grant_log.delete();
        req = 2'b11;
        for (int i = 0; i < 200 && grant_log.size() < 6; i++) tick();
        req = '0;
        repeat (12) tick();
        check("t3_grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("t3_grant%0d", i), grant_log[i], i % 2);

        // Hung multiplier: timeout response exactly TO cycles after WAIT entry.
        stub_hang = 1'b1;
        set_ops(0, 64'd11, 64'd13);
        req = 2'b01;
        wait_grant(10);
        begin
            int wait_entry;
            wait_entry = grant_cyc + 1;
            wait_rsp(0, TO + 20);
            check("t4_timeout_cycles", cyc - wait_entry, TO);
        end
        check("t4_err", rsp_err, 1'b1);
        check("t4_result", rsp_result, '0);
        check("t4_clear", mul_op_clear, 1'b1);
        stub_hang = 1'b0;
        set_ops(1, 64'd3, 64'd5);
        req = 2'b10;
        wait_rsp(1, 40);
        check("t4_next_result", rsp_result, 128'd15);
        check("t4_next_err", rsp_err, 1'b0);
        repeat (2) tick();

        // Reset while slot1 is waiting on the multiplier.
        stub_hang = 1'b1;
        set_ops(1, 64'd0, 64'd0);
        req = 2'b10;
        wait_grant(10);
        repeat (3) tick();
        v1_before = n_valid[1];
        reset_n = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_valid", n_valid[1], v1_before);
        model_reset();
        prev_grant = '0;
        stub_hang = 1'b0;
        req = '0;
        reset_n = 1'b1;
        grant_log.delete();
        req = 2'b10;
        wait_rsp(1, 40);
        check("midrst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
        repeat (2) tick();

        // Stale done held high in IDLE must not produce an early response.
        stub_stale = 1'b1;
        repeat (3) tick();
        set_ops(0, 64'd7, -64'sd7);
        req = 2'b01;
        wait_grant(10);
        stub_stale = 1'b0;
        wait_rsp(0, 40);
        check("t6_result", rsp_result, NEG49);
        check("t6_err", rsp_err, 1'b0);
        repeat (2) tick();

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            stub_lat = $urandom_range(0, 6);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    set_ops(i, {$urandom, $urandom}, {$urandom, $urandom});
                end else if (req[i] && grant[i] && $urandom_range(0, 49) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick();
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    if (req[i]) set_ops(i, {$urandom, $urandom}, {$urandom, $urandom});
                end
            end
        end
        req = '0;
        repeat (10) tick();
        check("final_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
